// File: rtl/pool_ifm_sender_if.sv
// pool_ifm_sender_if: bundles the IFM SRAM read port, the pooling-engine
// input port and the frame control/status lines of pool_ifm_sender.
// master = the sender itself, slave = whatever drives/observes it.
interface pool_ifm_sender_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  full;
    logic                  end_pool;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] ifm;
    logic                  channel_done;
    logic                  done;
    logic                  busy;

    modport master (
        input  start, full, end_pool, mem_rdata,
        output mem_rd_en, mem_addr, in_valid, ifm, channel_done, done, busy
    );

    modport slave (
        output start, full, end_pool, mem_rdata,
        input  mem_rd_en, mem_addr, in_valid, ifm, channel_done, done, busy
    );
endinterface

// File: rtl/pool_ifm_sender.sv
// pool_ifm_sender: streams CI channels of IFM_SIZE x IFM_SIZE pixels from the
// IFM SRAM into the pooling engine, one pixel per cycle when `full` is low.
// A 2-entry skid FIFO absorbs the 1-cycle SRAM read latency; reads are only
// issued when the FIFO is guaranteed to have room for the returning word.
// Optional feature macro: POOL_IFM_SENDER_WAIT_ACK_EN -- when defined, every
// channel but the last is held back until the pooling engine pulses end_pool.
module pool_ifm_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 27,
    parameter int CI         = 3,
    parameter int ADDR_WIDTH = $clog2(CI*IFM_SIZE*IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    pool_ifm_sender_if.master     bus
);
    localparam int PIX   = IFM_SIZE * IFM_SIZE;
    localparam int POS_W = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int CH_W  = (CI > 1) ? $clog2(CI) : 1;
    localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(IFM_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CI - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        DRAIN,
        FINISH
    } state_t;

    state_t                state;
    logic [POS_W-1:0]      col;
    logic [POS_W-1:0]      row;
    logic [CH_W-1:0]       ch;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  done_r;
    logic                  busy_r;

    // Skid FIFO and read-return tracking
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  rvalid;      // a read issued last cycle returns now
    logic [PIX_W-1:0]      xfer_cnt;

    logic                  pop;
    logic                  rd_room;
    logic                  rd_en;
    logic                  last_pix;
    logic                  last_ch;
    logic                  empty_next;

`ifdef POOL_IFM_SENDER_WAIT_ACK_EN
    logic                  ack;
`else
    logic                  unused_end_pool;
    assign unused_end_pool = bus.end_pool;
`endif

    // A pop happens whenever the FIFO has data and the engine is not full.
    // A new read may be issued only if every word already owed to the FIFO
    // (stored + returning now, minus the one leaving now) leaves a free slot.
    always_comb begin
        pop        = (occ != 2'd0) && !bus.full;
        rd_room    = ({1'b0, occ} + {2'b00, rvalid}) < (3'd2 + {2'b00, pop});
        rd_en      = (state == SEND) && rd_room;
        last_pix   = (col == POS_LAST) && (row == POS_LAST);
        last_ch    = (ch == CH_LAST);
        empty_next = !rvalid && (occ == {1'b0, pop});
    end

    assign bus.mem_rd_en    = rd_en;
    assign bus.mem_addr     = addr;
    assign bus.in_valid     = pop;
    assign bus.ifm          = (occ != 2'd0) ? fifo_mem[rd_ptr] : '0;
    assign bus.channel_done = pop && (xfer_cnt == PIX_LAST);
    assign bus.done         = done_r;
    assign bus.busy         = busy_r;

    // Frame sequencer: walks col/row/ch, issues reads, and paces channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            ch     <= '0;
            addr   <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
`ifdef POOL_IFM_SENDER_WAIT_ACK_EN
            ack    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SEND;
                        col    <= '0;
                        row    <= '0;
                        ch     <= '0;
                        addr   <= '0;
                        busy_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (rd_en) begin
                        addr <= addr + 1'b1;
                        if (col == POS_LAST) begin
                            col <= '0;
                            if (row == POS_LAST) begin
                                row <= '0;
                                ch  <= ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pix) begin
                            if (last_ch) begin
                                state <= DRAIN;
                            end
`ifdef POOL_IFM_SENDER_WAIT_ACK_EN
                            else begin
                                state <= WAIT_ACK;
                            end
`endif
                        end
                    end
                end
`ifdef POOL_IFM_SENDER_WAIT_ACK_EN
                WAIT_ACK: begin
                    // Ack only counts once this channel's last read is out.
                    if (ack && (occ == 2'd0) && !rvalid) begin
                        state <= SEND;
                        ack   <= 1'b0;
                    end else if (bus.end_pool) begin
                        ack <= 1'b1;
                    end
                end
`endif
                DRAIN: begin
                    // Leave as soon as the final word is being popped so
                    // that done lands exactly one cycle after it.
                    if (empty_next) begin
                        state  <= FINISH;
                        done_r <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy, read-return flag and per-channel pop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            rvalid   <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            rvalid <= rd_en;
            occ    <= occ + {1'b0, rvalid} - {1'b0, pop};
            if (rvalid) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                xfer_cnt <= (xfer_cnt == PIX_LAST) ? '0 : xfer_cnt + 1'b1;
            end
        end
    end

    // FIFO storage captures the SRAM word the cycle it returns.
    always_ff @(posedge clk) begin
        if (rvalid) begin
            fifo_mem[wr_ptr] <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/pool_ifm_sender.md
# pool_ifm_sender

Streams input feature-map pixels from an on-chip IFM SRAM into the pooling engine's input port (`in_valid`/`ifm`), honouring the engine's `full` backpressure. Reads CI channels of IFM_SIZE×IFM_SIZE pixels in channel-major, row-major order and issues one pixel per cycle when unblocked. Sits between the IFM memory and the pooling block, on the pooling clock domain that writes the pool input buffer.

## Interface
- `DATA_WIDTH`, 32, pixel width
- `IFM_SIZE`, 27, feature-map height = width
- `CI`, 3, channel count
- `ADDR_WIDTH`, `$clog2(CI*IFM_SIZE*IFM_SIZE)`, SRAM address width
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a frame when idle
- `full`  in  1  pooling input buffer full; no transfer while high
- `end_pool`  in  1  pooling engine finished current channel
- `mem_rd_en`  out  1  SRAM read strobe
- `mem_addr`  out  ADDR_WIDTH  SRAM read address
- `mem_rdata`  in  DATA_WIDTH  SRAM data, valid exactly 1 cycle after `mem_rd_en`
- `in_valid`  out  1  pixel transfer this cycle (drives pool `in_valid`)
- `ifm`  out  DATA_WIDTH  pixel data (drives pool `ifm`)
- `channel_done`  out  1  pulse with last transfer of each channel
- `done`  out  1  pulse one cycle after final transfer of frame
- `busy`  out  1  high from accepted `start` until `done`

## Operation
- States: IDLE, SEND, WAIT_ACK, DRAIN, FINISH.
- IDLE: `start`=1 → SEND, clear counters `col,row,ch`. `start` outside IDLE ignored.
- SEND: issue reads; address = ch·IFM_SIZE² + row·IFM_SIZE + col; col wraps at IFM_SIZE−1 → row++, row wraps → ch++.
- 2-entry output skid FIFO absorbs the 1-cycle SRAM latency. Read issued iff (occupancy + in-flight − pop_this_cycle) < 2.
- `in_valid` = FIFO non-empty AND `full`=0 (combinational on `full`); `ifm` = FIFO head; transfer = `in_valid`.
- After last read of a channel: last channel → DRAIN; otherwise WAIT_ACK (macro on) or stay in SEND (macro off).
- Transfer counter tracks pops; `channel_done` asserted in the cycle of each channel's IFM_SIZE²-th transfer.
- WAIT_ACK: no reads; FIFO keeps draining. Leaves to SEND when ack flag set AND FIFO empty AND nothing in flight; flag cleared on exit.
- Ack flag: set by `end_pool` at any time after the channel's final read is issued; earlier `end_pool` pulses ignored.
- DRAIN: wait FIFO empty and nothing in flight → FINISH. FINISH: `done`=1 one cycle → IDLE.
- Total transfers per frame exactly CI·IFM_SIZE²; no duplicates, no drops under any `full` pattern.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `in_valid`=0, `ifm`=0, `channel_done`=0, `done`=0, `busy`=0; FIFO flushed, in-flight read discarded, state IDLE.
- `rst` mid-frame: same as above next cycle; returning `mem_rdata` ignored.
- `start` sampled cycle 0 → `mem_rd_en` addr 0 cycle 1 → `in_valid` earliest cycle 3.
- `full`=0 steady: one transfer per cycle, no bubbles within a channel.
- `full` rising: `in_valid` drops same cycle; at most one read in flight lands in FIFO; no overflow.
- `full` falling: `in_valid` same cycle if FIFO non-empty.
- `busy` high from cycle 1 through the `done` cycle.

## Configuration
- `POOL_IFM_SENDER_WAIT_ACK_EN` defined: WAIT_ACK state used; each channel (except last) gated on `end_pool`.
- Undefined: WAIT_ACK compiled out, `end_pool` unused; channels stream back-to-back with no bubble at channel boundaries.

## Test plan
- IFM_SIZE=3, CI=1, SRAM word = address, `full`=0, `start` → 9 transfers `ifm`=0..8 on consecutive cycles from cycle 3, `channel_done` with 8, `done` next cycle.
- Same, `full` toggled 1/0 each cycle → exactly values 0..8 in order, `in_valid`=0 in every full=1 cycle.
- `full` held 1 for 20 cycles after start → FIFO holds 2, `mem_rd_en` stops; release → 0..8 delivered intact.
- Macro on, CI=2, IFM_SIZE=3: `end_pool` withheld → stop after 9 transfers, no `mem_rd_en`; pulse `end_pool` → addresses 9..17 read, transfers resume.
- `rst` asserted after 4 transfers → all outputs 0 next cycle; fresh `start` → restarts at value 0.
- `start` pulsed while busy → ignored; total transfers still CI·IFM_SIZE², single `done`.
